// File: rtl/eth_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_scheduler
// Purpose  : Round-robin frame scheduler for the shared RMII TX byte path.
//            It adds the preamble and SFD, paces one byte per slot and
//            enforces the inter-frame gap. TX_PAD_EN enables zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_scheduler #(
    parameter int NUM_SRC     = 2,
    parameter int BYTE_CYCLES = 4,
    parameter int IFG_BYTES   = 12,
    parameter int MIN_FRAME   = 60
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [8*NUM_SRC-1:0]       src_data,
    input  logic [NUM_SRC-1:0]         src_last,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       axiov,
    output logic [7:0]                 axiod,
    output logic                       tx_busy,
    output logic                       underrun,
    output logic [$clog2(NUM_SRC)-1:0] grant
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int SW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam int CW = $clog2(IFG_BYTES + 8);
`ifdef TX_PAD_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_GAP      = 3'd4
`ifdef TX_PAD_EN
        , S_PAD    = 3'd5
`endif
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] slot_cnt, slot_n;
    logic [CW-1:0] sym_cnt, sym_n;
    logic [10:0]   byte_cnt, byte_n, byte_inc;
    logic [GW-1:0] rr, rr_n, grant_n, pick;
    logic [GW:0]   rot_sum;
    logic          slot, emit, und_n;
    logic [7:0]    emit_data, cur_data;
    logic          cur_valid, cur_last;

    assign slot      = (slot_cnt == '0);
    assign cur_data  = src_data[{grant, 3'b000} +: 8];
    assign cur_valid = src_valid[grant];
    assign cur_last  = src_last[grant];
    assign byte_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign tx_busy   = (state != S_IDLE);

    // Descending scan so the lowest offset from the RR pointer wins.
    always_comb begin
        pick    = rr;
        rot_sum = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            rot_sum = {1'b0, rr} + (GW+1)'(i);
            if (rot_sum >= (GW+1)'(NUM_SRC)) begin
                rot_sum = rot_sum - (GW+1)'(NUM_SRC);
            end
            if (src_valid[rot_sum[GW-1:0]]) begin
                pick = rot_sum[GW-1:0];
            end
        end
    end

    // Only the granted source sees a ready strobe, and only on a payload slot.
    always_comb begin
        src_ready = '0;
        if (!rst && state == S_PAYLOAD && slot) begin
            src_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        sym_n     = sym_cnt;
        byte_n    = byte_cnt;
        grant_n   = grant;
        rr_n      = rr;
        emit      = 1'b0;
        emit_data = axiod;
        und_n     = 1'b0;
        slot_n    = (slot_cnt == SW'(BYTE_CYCLES - 1)) ? '0 : slot_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                slot_n = '0;
                if (|src_valid) begin
                    grant_n = pick;
                    sym_n   = '0;
                    byte_n  = '0;
                    state_n = S_PREAMBLE;
                end
            end
            S_PREAMBLE: if (slot) begin
                emit      = 1'b1;
                emit_data = 8'h55;
                if (sym_cnt == CW'(6)) begin
                    sym_n   = '0;
                    state_n = S_SFD;
                end else begin
                    sym_n = sym_cnt + 1'b1;
                end
            end
            S_SFD: if (slot) begin
                emit      = 1'b1;
                emit_data = 8'hD5;
                state_n   = S_PAYLOAD;
            end
            S_PAYLOAD: if (slot) begin
                sym_n = '0;
                if (cur_valid) begin
                    emit      = 1'b1;
                    emit_data = cur_data;
                    byte_n    = byte_inc;
                    if (cur_last) begin
`ifdef TX_PAD_EN
                        state_n = (byte_inc < MIN_CNT) ? S_PAD : S_GAP;
`else
                        state_n = S_GAP;
`endif
                    end
                end else begin
                    und_n   = 1'b1;
                    state_n = S_GAP;
                end
            end
`ifdef TX_PAD_EN
            S_PAD: if (slot) begin
                emit      = 1'b1;
                emit_data = 8'h00;
                byte_n    = byte_inc;
                if (byte_inc >= MIN_CNT) begin
                    state_n = S_GAP;
                end
            end
`endif
            S_GAP: if (slot) begin
                if (sym_cnt == CW'(IFG_BYTES - 1)) begin
                    sym_n   = '0;
                    slot_n  = '0;
                    rr_n    = (grant == GW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
                    state_n = S_IDLE;
                end else begin
                    sym_n = sym_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            slot_cnt <= '0;
            sym_cnt  <= '0;
            byte_cnt <= '0;
            grant    <= '0;
            rr       <= '0;
            axiov    <= 1'b0;
            axiod    <= 8'h00;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            slot_cnt <= slot_n;
            sym_cnt  <= sym_n;
            byte_cnt <= byte_n;
            grant    <= grant_n;
            rr       <= rr_n;
            axiov    <= emit;
            underrun <= und_n;
            if (emit) begin
                axiod <= emit_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_scheduler.sv
`default_nettype none
// Testbench for eth_tx_scheduler: randomized frames checked against a frame-level model.
module tb_eth_tx_scheduler;
    localparam int NUM_SRC   = 2;
    localparam int BC        = 4;
    localparam int IFG       = 12;
    localparam int MIN_FRAME = 60;
    localparam int FRAME_GAP = IFG * BC + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SRC-1:0] src_valid, src_last, src_ready;
    logic [15:0]        src_data;
    logic               axiov, tx_busy, underrun;
    logic [7:0]         axiod;
    logic [0:0]         grant;

    eth_tx_scheduler #(.NUM_SRC(NUM_SRC), .BYTE_CYCLES(BC), .IFG_BYTES(IFG), .MIN_FRAME(MIN_FRAME)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .axiov(axiov), .axiod(axiod), .tx_busy(tx_busy),
        .underrun(underrun), .grant(grant));

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    logic [8:0] q0[$], q1[$];
    int stop0 = -1, stop1 = -1;
    logic [1:0] acc;
    logic [7:0] out_b[$];
    int out_t[$], rdy0_t[$], rdy1_t[$], und_t[$], fall_t[$], gnt_log[$];
    logic prev_busy;
    logic [7:0] pend0[$], pend1[$], exp_b[$];
    int exp_gap[$], exp_src[$];
    int model_rr = 0;

    // Source models: present the queue head, pop once the DUT has taken it.
    initial begin
        src_valid = '0; src_data = '0; src_last = '0; acc = '0;
        forever begin
            @(negedge clk);
            if (acc[0] && q0.size() > 0) begin void'(q0.pop_front()); if (stop0 > 0) stop0--; end
            if (acc[1] && q1.size() > 0) begin void'(q1.pop_front()); if (stop1 > 0) stop1--; end
            src_valid[0]   = (q0.size() > 0) && (stop0 != 0);
            src_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            src_last[0]    = (q0.size() > 0) && q0[0][8];
            src_valid[1]   = (q1.size() > 0) && (stop1 != 0);
            src_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            src_last[1]    = (q1.size() > 0) && q1[0][8];
            #1;
            acc = src_ready & src_valid;
        end
    end

    initial begin
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (axiov) begin out_b.push_back(axiod); out_t.push_back(cyc); end
            if (src_ready[0]) rdy0_t.push_back(cyc);
            if (src_ready[1]) rdy1_t.push_back(cyc);
            if (underrun) und_t.push_back(cyc);
            if (prev_busy && !tx_busy) fall_t.push_back(cyc);
            if (!prev_busy && tx_busy) gnt_log.push_back(int'(grant));
            prev_busy = tx_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs;
        out_b.delete(); out_t.delete(); rdy0_t.delete(); rdy1_t.delete();
        und_t.delete(); fall_t.delete(); gnt_log.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        q0.delete(); q1.delete(); pend0.delete(); pend1.delete();
        stop0 = -1; stop1 = -1;
        step(3);
        rst = 1'b0;
        model_rr = 0;
        step(1);
        clear_logs();
    endtask

    task automatic push_frame(input int src, input int len, input bit fixed);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = fixed ? 8'(i + 1) : 8'($urandom);
            if (src == 0) begin q0.push_back({(i == len - 1), b}); pend0.push_back(b); end
            else          begin q1.push_back({(i == len - 1), b}); pend1.push_back(b); end
        end
    endtask

    // Reference: pending frames leave in round-robin order, each as preamble, SFD, payload.
    task automatic model_schedule;
        int s;
        logic [7:0] pl[$];
        exp_b.delete(); exp_gap.delete(); exp_src.delete();
        while (pend0.size() > 0 || pend1.size() > 0) begin
            s = model_rr;
            if (s == 0 && pend0.size() == 0) s = 1;
            else if (s == 1 && pend1.size() == 0) s = 0;
            if (s == 0) begin pl = pend0; pend0.delete(); end
            else        begin pl = pend1; pend1.delete(); end
`ifdef TX_PAD_EN
            while (pl.size() < MIN_FRAME) pl.push_back(8'h00);
`endif
            for (int i = 0; i < 8 + pl.size(); i++) begin
                exp_b.push_back((i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : pl[i-8]);
                exp_gap.push_back((i == 0) ? FRAME_GAP : BC);
            end
            exp_src.push_back(s);
            model_rr = (s + 1) % NUM_SRC;
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        step(3);
        while ((q0.size() > 0 && stop0 != 0) || (q1.size() > 0 && stop1 != 0) || tx_busy) begin
            step(1);
            n++;
            if (n > max_cyc) begin
                total++; bad++;
                $display("FAIL %s timeout: waited %0d cycles, limit %0d", name, n, max_cyc);
                return;
            end
        end
        step(2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        total += 6;
        if (axiov !== 1'b0)    begin bad++; $display("FAIL reset axiov: got %b want 0", axiov); end
        if (axiod !== 8'h00)   begin bad++; $display("FAIL reset axiod: got %h want 00", axiod); end
        if (tx_busy !== 1'b0)  begin bad++; $display("FAIL reset tx_busy: got %b want 0", tx_busy); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL reset underrun: got %b want 0", underrun); end
        if (grant !== 1'b0)    begin bad++; $display("FAIL reset grant: got %0d want 0", grant); end
        if (src_ready !== 2'b00) begin bad++; $display("FAIL reset src_ready: got %b want 00", src_ready); end
        do_reset();
    endtask

    task automatic test_single_frame;
        int c, n;
        do_reset();
        c = cyc;
        push_frame(0, 3, 1'b1);
        model_schedule();
        wait_idle(1000, "single");
        n = out_b.size();
        total++;
        if (n != exp_b.size()) begin bad++; $display("FAIL single count: got %0d want %0d", n, exp_b.size()); end
        for (int i = 0; i < n && i < exp_b.size(); i++) begin
            total++;
            if (out_b[i] !== exp_b[i]) begin bad++; $display("FAIL single byte[%0d]: got %h want %h", i, out_b[i], exp_b[i]); end
            if (i > 0) begin
                total++;
                if (out_t[i] - out_t[i-1] != BC) begin bad++; $display("FAIL single spacing[%0d]: got %0d want %0d", i, out_t[i] - out_t[i-1], BC); end
            end
        end
        total += 4;
        if (n == 0 || out_t[0] != c + 2) begin bad++; $display("FAIL single latency: got %0d want %0d", (n > 0) ? out_t[0] - c : -1, 2); end
        if (und_t.size() != 0)  begin bad++; $display("FAIL single underrun: got %0d pulses want 0", und_t.size()); end
        if (rdy1_t.size() != 0) begin bad++; $display("FAIL single foreign ready: got %0d want 0", rdy1_t.size()); end
        if (rdy0_t.size() != 3) begin bad++; $display("FAIL single ready count: got %0d want 3", rdy0_t.size()); end
        for (int i = 0; i < 3 && i < rdy0_t.size() && 8 + i < n; i++) begin
            total++;
            if (out_t[8+i] != rdy0_t[i] + 1) begin bad++; $display("FAIL single ready-to-byte[%0d]: got %0d want 1", i, out_t[8+i] - rdy0_t[i]); end
        end
        total++;
        if (fall_t.size() != 1 || n == 0 || fall_t[0] != out_t[n-1] + IFG * BC)
            begin bad++; $display("FAIL single busy drop: got %0d want %0d", (fall_t.size() > 0 && n > 0) ? fall_t[0] - out_t[n-1] : -1, IFG * BC); end
    endtask

    task automatic test_contention;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            push_frame(0, $urandom_range(1, 8), 1'b0);
            push_frame(1, $urandom_range(1, 8), 1'b0);
            model_schedule();
            wait_idle(3000, "contention");
            total++;
            if (out_b.size() != exp_b.size()) begin bad++; $display("FAIL contention[%0d] count: got %0d want %0d", r, out_b.size(), exp_b.size()); end
            for (int i = 0; i < out_b.size() && i < exp_b.size(); i++) begin
                total++;
                if (out_b[i] !== exp_b[i]) begin bad++; $display("FAIL contention[%0d] byte[%0d]: got %h want %h", r, i, out_b[i], exp_b[i]); end
                if (i > 0) begin
                    total++;
                    if (out_t[i] - out_t[i-1] != exp_gap[i]) begin bad++; $display("FAIL contention[%0d] spacing[%0d]: got %0d want %0d", r, i, out_t[i] - out_t[i-1], exp_gap[i]); end
                end
            end
            total++;
            if (gnt_log.size() != 2 || gnt_log[0] != exp_src[0] || gnt_log[1] != exp_src[1])
                begin bad++; $display("FAIL contention[%0d] grant order: got %0d frames first=%0d want first=%0d", r, gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1, exp_src[0]); end
        end
    endtask

    task automatic test_underrun;
        logic [7:0] b0;
        do_reset();
        push_frame(1, 4, 1'b0);
        b0 = q1[0][7:0];
        pend1.delete();
        stop1 = 1;
        wait_idle(1000, "underrun");
        total += 5;
        if (out_b.size() != 9) begin bad++; $display("FAIL underrun count: got %0d want 9", out_b.size()); end
        if (out_b.size() < 9 || out_b[8] !== b0) begin bad++; $display("FAIL underrun byte: got %h want %h", (out_b.size() > 8) ? out_b[8] : 8'hxx, b0); end
        if (und_t.size() != 1) begin bad++; $display("FAIL underrun pulses: got %0d want 1", und_t.size()); end
        if (und_t.size() < 1 || out_b.size() < 9 || und_t[0] != out_t[8] + BC)
            begin bad++; $display("FAIL underrun timing: got %0d want %0d", (und_t.size() > 0 && out_b.size() > 8) ? und_t[0] - out_t[8] : -1, BC); end
        if (fall_t.size() != 1 || und_t.size() < 1 || fall_t[0] != und_t[0] + IFG * BC)
            begin bad++; $display("FAIL underrun gap: got %0d want %0d", (fall_t.size() > 0 && und_t.size() > 0) ? fall_t[0] - und_t[0] : -1, IFG * BC); end
        total++;
        if (rdy1_t.size() != 2) begin bad++; $display("FAIL underrun ready pulses: got %0d want 2", rdy1_t.size()); end
        q1.delete();
        stop1 = -1;
    endtask

    task automatic test_reset_mid_frame;
        int n, p;
        do_reset();
        push_frame(0, 10, 1'b0);
        n = 0;
        while (rdy0_t.size() < 4 && n < 300) begin step(1); n++; end
        total++;
        if (rdy0_t.size() < 4) begin bad++; $display("FAIL reset_mid reach byte4: got %0d pulses want 4", rdy0_t.size()); end
        p = (rdy0_t.size() >= 4) ? rdy0_t[3] : cyc;
        while (cyc < p + BC) step(1);
        rst = 1'b1;
        #1;
        total++;
        if (src_ready !== 2'b00) begin bad++; $display("FAIL reset_mid ready in rst cycle: got %b want 00", src_ready); end
        step(1);
        total += 2;
        if (axiov !== 1'b0)   begin bad++; $display("FAIL reset_mid axiov: got %b want 0", axiov); end
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_mid tx_busy: got %b want 0", tx_busy); end
        q0.delete(); pend0.delete();
        step(2);
        rst = 1'b0;
        model_rr = 0;
        step(2 * BC);
        total += 2;
        if (out_b.size() != 12) begin bad++; $display("FAIL reset_mid bytes out: got %0d want 12", out_b.size()); end
        if (grant !== 1'b0) begin bad++; $display("FAIL reset_mid grant: got %0d want 0", grant); end
        clear_logs();
        push_frame(0, 3, 1'b0);
        model_schedule();
        wait_idle(1000, "reset_mid restart");
        total++;
        if (out_b.size() != exp_b.size()) begin bad++; $display("FAIL restart count: got %0d want %0d", out_b.size(), exp_b.size()); end
        for (int i = 0; i < out_b.size() && i < exp_b.size(); i++) begin
            total++;
            if (out_b[i] !== exp_b[i]) begin bad++; $display("FAIL restart byte[%0d]: got %h want %h", i, out_b[i], exp_b[i]); end
        end
        total++;
        if (gnt_log.size() != 1 || gnt_log[0] != 0) begin bad++; $display("FAIL restart grant: got %0d want 0", (gnt_log.size() > 0) ? gnt_log[0] : -1); end
    endtask

    task automatic test_pacing;
        do_reset();
        push_frame(0, 64, 1'b0);
        model_schedule();
        wait_idle(3000, "pacing");
        total += 2;
        if (rdy0_t.size() != 64) begin bad++; $display("FAIL pacing ready count: got %0d want 64", rdy0_t.size()); end
        if (out_b.size() != exp_b.size()) begin bad++; $display("FAIL pacing count: got %0d want %0d", out_b.size(), exp_b.size()); end
        for (int i = 1; i < rdy0_t.size(); i++) begin
            total++;
            if (rdy0_t[i] - rdy0_t[i-1] != BC) begin bad++; $display("FAIL pacing ready[%0d]: got %0d want %0d", i, rdy0_t[i] - rdy0_t[i-1], BC); end
        end
        for (int i = 0; i < out_b.size() && i < exp_b.size(); i++) begin
            total++;
            if (out_b[i] !== exp_b[i]) begin bad++; $display("FAIL pacing byte[%0d]: got %h want %h", i, out_b[i], exp_b[i]); end
        end
    endtask

    task automatic test_random_traffic;
        int m, l0, l1;
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            step($urandom_range(0, 5));
            m  = $urandom_range(1, 3);
            l0 = (m[0]) ? $urandom_range(1, 24) : 0;
            l1 = (m[1]) ? $urandom_range(1, 24) : 0;
            if (l0 > 0) push_frame(0, l0, 1'b0);
            if (l1 > 0) push_frame(1, l1, 1'b0);
            model_schedule();
            wait_idle(4000, "random");
            total += 3;
            if (out_b.size() != exp_b.size()) begin bad++; $display("FAIL random[%0d] count: got %0d want %0d", r, out_b.size(), exp_b.size()); end
            if (rdy0_t.size() != l0 || rdy1_t.size() != l1)
                begin bad++; $display("FAIL random[%0d] ready pulses: got %0d/%0d want %0d/%0d", r, rdy0_t.size(), rdy1_t.size(), l0, l1); end
            if (gnt_log.size() != exp_src.size() || gnt_log[0] != exp_src[0])
                begin bad++; $display("FAIL random[%0d] grant: got %0d want %0d", r, (gnt_log.size() > 0) ? gnt_log[0] : -1, exp_src[0]); end
            for (int i = 0; i < out_b.size() && i < exp_b.size(); i++) begin
                total++;
                if (out_b[i] !== exp_b[i]) begin bad++; $display("FAIL random[%0d] byte[%0d]: got %h want %h", r, i, out_b[i], exp_b[i]); end
                if (i > 0) begin
                    total++;
                    if (out_t[i] - out_t[i-1] != exp_gap[i]) begin bad++; $display("FAIL random[%0d] spacing[%0d]: got %0d want %0d", r, i, out_t[i] - out_t[i-1], exp_gap[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_underrun();
        test_reset_mid_frame();
        test_pacing();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
